cacheline_adaptor_param: RTL and testbench
==========================================

Name: cacheline_adaptor_param

Overview:
Parametrised next-generation adaptor between the last-level cache (one full line per transaction) and a burst memory port (fixed-width beats). It generalises line width, beat width and address width, and registers request address and write data at acceptance. It adds an optional critical-word-first (wrap-order) mode for reads and writes. It sits between the LLC miss/writeback logic and the physical memory model/controller.

Parameters:
LINE_W, 256, cache line width in bits
BURST_W, 64, memory beat width in bits
ADDR_W, 32, address width
WRAP_EN, 0, 1 = beat order starts at the addressed beat and wraps; 0 = beat 0 first
(derived) BEATS = LINE_W/BURST_W; OFS_LO = $clog2(BURST_W/8); OFS_W = $clog2(BEATS)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
line_i  in  LINE_W  write line from LLC
line_o  out  LINE_W  read line to LLC
address_i  in  ADDR_W  request address
read_i  in  1  read request, held until resp_o
write_i  in  1  write request, held until resp_o
resp_o  out  1  one-cycle completion pulse
burst_i  in  BURST_W  read beat from memory
burst_o  out  BURST_W  write beat to memory
address_o  out  ADDR_W  memory address (registered)
read_o  out  1  memory read request
write_o  out  1  memory write request
resp_i  in  1  memory beat acknowledge

Behaviour:
- Elaboration checks: LINE_W % BURST_W == 0; BEATS a power of two, >= 2; violation -> $error.
- Reset (async assert, sync release): state IDLE; line_o, burst_o, address_o, beat count, start index = 0; read_o, write_o, resp_o = 0.
- States: IDLE, READ, READ_DONE, WRITE, WRITE_DONE.
- IDLE: read_i -> READ; else write_i -> WRITE (read wins on simultaneous request). On acceptance latch address_o, start = WRAP_EN ? address_i[OFS_LO +: OFS_W] : 0, cnt = 0, and, for writes, the write line. When WRAP_EN = 0, the low log2(LINE_W/8) bits of address_o are forced to 0. resp_i in IDLE is ignored.
- READ: read_o = 1. Each cycle with resp_i: line_o[BURST_W*((start+cnt) mod BEATS) +: BURST_W] <= burst_i; cnt++. On the BEATS-th beat go to READ_DONE. read_o is low from READ_DONE onward.
- READ_DONE: resp_o = 1 for exactly one cycle; line_o holds the complete line. Next state is IDLE. line_o holds its value until the next read overwrites it.
- WRITE: write_o = 1; burst_o = latched line at beat index (start+cnt) mod BEATS, combinationally from cnt. Each resp_i advances cnt. After the BEATS-th beat go to WRITE_DONE with write_o = 0.
- WRITE_DONE: resp_o = 1 for one cycle, then IDLE.
- Changes to read_i, write_i, address_i or line_i while busy have no effect. Requests still asserted during a DONE cycle are not re-accepted. A request seen in IDLE on the cycle after DONE is a new transaction.
- Index arithmetic is OFS_W bits wide with natural wrap. cnt is $clog2(BEATS+1) bits wide.
- Latency with memory acking every cycle: request -> resp_o = BEATS + 2 cycles.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs 0, partial line discarded.

Decomposition:
- Package cacheline_adaptor_pkg: state enum type and helper function beat_idx(start, cnt).
- Sub-module cla_beat_ctr: cnt/start registers, next-index computation and last-beat flag, parametrised on BEATS. Both the read and write paths reuse it.

Test Plan:
- Default params, read of 0x0000_1040, memory acks 4 consecutive cycles with 0xA0..A3 -> read_o high 4 cycles; resp_o pulses at cycle 6; line_o = {A3,A2,A1,A0}; address_o = 0x0000_1040.
- Write, line_i = {D3,D2,D1,D0}, acks with 2 idle gaps -> burst_o = D0,D1,D2,D3 in order; write_o drops after the 4th ack; one resp_o pulse.
- WRAP_EN = 1, read at 0x...1050 (beat 2), beats B0..B3 -> stored at indices 2,3,0,1; line_o = {B1,B0,B3,B2}; address_o = 0x...1050.
- read_i and write_i both high in IDLE -> read performed only; write taken afterward if write_i is still held.
- reset_n low after 2 read beats -> outputs 0 same cycle. After release, a new read completes normally with no stale data.
- LINE_W = 512, BURST_W = 128 -> 4 beats; full read and write round-trips match the reference model.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and index helper for the cache-line <-> burst adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    READ_DONE,
    WRITE,
    WRITE_DONE
  } state_t;

  // Beat slot for the cnt-th transferred beat when the burst starts at slot start.
  function automatic int unsigned beat_idx(int unsigned start, int unsigned cnt,
                                           int unsigned beats);
    return (start + cnt) % beats;
  endfunction

endpackage

// File: rtl/cla_beat_ctr.sv
// Beat counter shared by the read and write paths: start slot, transferred-beat
// count, current line slot and a flag marking the final acknowledged beat.
module cla_beat_ctr
  import cacheline_adaptor_pkg::*;
#(
  parameter  int BEATS = 4,
  localparam int OFS_W = $clog2(BEATS),
  localparam int CNT_W = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [OFS_W-1:0] load_start,
  input  logic             adv,
  output logic [OFS_W-1:0] idx,
  output logic             last
);

  logic [CNT_W-1:0] cnt;
  logic [OFS_W-1:0] start;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      start <= '0;
    end else if (load) begin
      cnt   <= '0;
      start <= load_start;
    end else if (adv) begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign idx  = OFS_W'(beat_idx(32'(start), 32'(cnt), 32'(BEATS)));
  assign last = adv && (cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/cacheline_adaptor_param.sv
// LLC line <-> memory burst adaptor with optional critical-word-first ordering.
// Request address and write line are captured at acceptance; busy-time input changes are ignored.
module cacheline_adaptor_param
  import cacheline_adaptor_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32,
  parameter bit WRAP_EN = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int OFS_LO = $clog2(BURST_W / 8);
  localparam int OFS_W  = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
    $error("cacheline_adaptor_param: LINE_W/BURST_W must be a power of two >= 2");
  end

  state_t           state, nxt;
  logic [LINE_W-1:0] wline;
  logic [OFS_W-1:0] idx;
  logic             last;
  logic             accept_rd, accept_wr, adv;

  assign accept_rd = (state == IDLE) && read_i;
  assign accept_wr = (state == IDLE) && !read_i && write_i;
  assign adv       = ((state == READ) || (state == WRITE)) && resp_i;

  cla_beat_ctr #(.BEATS(BEATS)) u_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept_rd || accept_wr),
    .load_start(WRAP_EN ? address_i[OFS_LO +: OFS_W] : '0),
    .adv       (adv),
    .idx       (idx),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line_o    <= '0;
      wline     <= '0;
      address_o <= '0;
    end else begin
      state <= nxt;
      // Without wrap ordering the burst always starts line-aligned.
      if (accept_rd || accept_wr)
        address_o <= WRAP_EN ? address_i : (address_i & LINE_MASK);
      if (accept_wr)
        wline <= line_i;
      if ((state == READ) && resp_i)
        line_o[BURST_W*idx +: BURST_W] <= burst_i;
    end
  end

  always_comb begin
    nxt     = state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state)
      IDLE: begin
        if (read_i)       nxt = READ;
        else if (write_i) nxt = WRITE;
      end
      READ: begin
        read_o = 1'b1;
        if (last) nxt = READ_DONE;
      end
      READ_DONE: begin
        resp_o = 1'b1;
        nxt    = IDLE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wline[BURST_W*idx +: BURST_W];
        if (last) nxt = WRITE_DONE;
      end
      WRITE_DONE: begin
        resp_o = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor_param.sv
// Bench for cacheline_adaptor_param: three configurations share stimulus, one active at a time.
// Expected lines/beats come from a slot-ordering model computed with plain arithmetic.
module tb_cacheline_adaptor_param;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int           sel;
  logic         rd, wr, ack;
  logic [511:0] line_in;
  logic [31:0]  addr_in;
  logic [127:0] bin;

  logic [255:0] lo0, lo1;
  logic [511:0] lo2;
  logic [63:0]  bo0, bo1;
  logic [127:0] bo2;
  logic [31:0]  ao0, ao1, ao2;
  logic         ro0, ro1, ro2, wo0, wo1, wo2, rs0, rs1, rs2;

  logic [511:0] lo;
  logic [127:0] bo;
  logic [31:0]  ao;
  logic         ro, wo, rs;

  int checks = 0;
  int failures = 0;

  cacheline_adaptor_param #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .WRAP_EN(1'b0)) d0 (
    .clk(clk), .reset_n(reset_n), .line_i(line_in[255:0]), .line_o(lo0),
    .address_i(addr_in), .read_i(rd && sel == 0), .write_i(wr && sel == 0), .resp_o(rs0),
    .burst_i(bin[63:0]), .burst_o(bo0), .address_o(ao0), .read_o(ro0), .write_o(wo0),
    .resp_i(ack && sel == 0));

  cacheline_adaptor_param #(.LINE_W(256), .BURST_W(64), .ADDR_W(32), .WRAP_EN(1'b1)) d1 (
    .clk(clk), .reset_n(reset_n), .line_i(line_in[255:0]), .line_o(lo1),
    .address_i(addr_in), .read_i(rd && sel == 1), .write_i(wr && sel == 1), .resp_o(rs1),
    .burst_i(bin[63:0]), .burst_o(bo1), .address_o(ao1), .read_o(ro1), .write_o(wo1),
    .resp_i(ack && sel == 1));

  cacheline_adaptor_param #(.LINE_W(512), .BURST_W(128), .ADDR_W(32), .WRAP_EN(1'b0)) d2 (
    .clk(clk), .reset_n(reset_n), .line_i(line_in), .line_o(lo2),
    .address_i(addr_in), .read_i(rd && sel == 2), .write_i(wr && sel == 2), .resp_o(rs2),
    .burst_i(bin), .burst_o(bo2), .address_o(ao2), .read_o(ro2), .write_o(wo2),
    .resp_i(ack && sel == 2));

  always_comb begin
    lo = {256'b0, lo0}; bo = {64'b0, bo0}; ao = ao0; ro = ro0; wo = wo0; rs = rs0;
    if (sel == 1) begin
      lo = {256'b0, lo1}; bo = {64'b0, bo1}; ao = ao1; ro = ro1; wo = wo1; rs = rs1;
    end else if (sel == 2) begin
      lo = lo2; bo = bo2; ao = ao2; ro = ro2; wo = wo2; rs = rs2;
    end
  end

  // ---- reference model: configuration of the active instance ----
  function automatic int bw_of();   return (sel == 2) ? 128 : 64;  endfunction
  function automatic int lw_of();   return (sel == 2) ? 512 : 256; endfunction
  function automatic bit wrap_of(); return sel == 1;               endfunction

  function automatic logic [127:0] bmask();
    logic [127:0] m;
    m = '1;
    if (bw_of() < 128) m = (128'(1) << bw_of()) - 128'(1);
    return m;
  endfunction

  function automatic int start_of(logic [31:0] a);
    int bytes_per_beat = bw_of() / 8;
    return wrap_of() ? int'((a / bytes_per_beat) % 4) : 0;
  endfunction

  function automatic logic [31:0] exp_addr(logic [31:0] a);
    return wrap_of() ? a : (a - (a % (lw_of() / 8)));
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Read: beat k of the burst lands in line slot (start+k) mod 4.
  task automatic do_read(input logic [31:0] a, input logic [3:0][127:0] b,
                         input logic [15:0] gaps, input bit chk_lat);
    logic [511:0] want;
    int bw, st, cyc;
    bw = bw_of(); st = start_of(a); want = '0;
    for (int k = 0; k < 4; k++)
      want |= 512'(b[k] & bmask()) << (bw * ((st + k) % 4));
    rd = 1'b1; addr_in = a; cyc = 1;   // request cycle counts as cycle 1
    @(negedge clk); cyc++;
    chk("rd_req", ro, 1); chk("rd_addr", ao, exp_addr(a));
    addr_in = $urandom;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
        ack = 1'b0; bin = $urandom;
        @(negedge clk); cyc++;
        chk("rd_req_wait", ro, 1);
      end
      ack = 1'b1; bin = b[k];
      @(negedge clk); cyc++;
    end
    ack = 1'b0;
    chk("rd_resp", rs, 1); chk("rd_req_low", ro, 0); chk("rd_no_wr", wo, 0);
    chk("rd_line", lo, want); chk("rd_addr_hold", ao, exp_addr(a));
    if (chk_lat) chk("rd_latency", 512'(cyc), 512'(6));
    rd = 1'b0;
    @(negedge clk);
    chk("rd_resp_once", rs, 0); chk("rd_line_hold", lo, want);
  endtask

  // Write: the k-th acknowledged beat is line slot (start+k) mod 4.
  task automatic do_write(input logic [31:0] a, input logic [511:0] l, input logic [15:0] gaps);
    logic [127:0] want;
    int bw, st;
    bw = bw_of(); st = start_of(a);
    wr = 1'b1; addr_in = a; line_in = l;
    @(negedge clk);
    chk("wr_req", wo, 1); chk("wr_addr", ao, exp_addr(a));
    for (int i = 0; i < 16; i++) line_in[32*i +: 32] = $urandom;
    addr_in = $urandom;
    for (int k = 0; k < 4; k++) begin
      want = 128'(l >> (bw * ((st + k) % 4))) & bmask();
      for (int g = 0; g < int'(gaps[4*k +: 4]); g++) begin
        chk("wr_beat_wait", bo, want);
        @(negedge clk);
      end
      chk("wr_beat", bo, want); chk("wr_req_hi", wo, 1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    chk("wr_req_low", wo, 0); chk("wr_resp", rs, 1);
    wr = 1'b0;
    @(negedge clk);
    chk("wr_resp_once", rs, 0);
  endtask

  function automatic logic [3:0][127:0] rand_beats();
    logic [3:0][127:0] b;
    for (int k = 0; k < 4; k++) b[k] = {$urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    rd = 0; wr = 0; ack = 0; sel = 0; line_in = '0; addr_in = '0; bin = '0;
    reset_n = 1'b0;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_line", lo, 0); chk("rst_burst", bo, 0); chk("rst_addr", ao, 0);
      chk("rst_ctl", {ro, wo, rs}, 0);
    end
    sel = 0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // stray memory ack while idle must not advance anything
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    do_read(32'h0000_1040, {128'hA3, 128'hA2, 128'hA1, 128'hA0}, 16'h0000, 1'b1);
    do_write(32'h0000_2000, {256'b0, 64'hD3, 64'hD2, 64'hD1, 64'hD0}, 16'h1010);

    // critical-word-first read starting at beat 2
    sel = 1;
    do_read(32'h0000_1050, {128'hB3, 128'hB2, 128'hB1, 128'hB0}, 16'h0000, 1'b1);
    chk("wrap_line", lo, {256'b0, 64'hB1, 64'hB0, 64'hB3, 64'hB2});

    // simultaneous request: read first, held write taken afterwards
    sel = 0; wr = 1'b1;
    do_read($urandom, rand_beats(), 16'h0000, 1'b0);
    do_write($urandom, rand_line(), 16'h0201);

    // reset in the middle of a read
    rd = 1'b1; addr_in = 32'h0000_3000;
    @(negedge clk);
    ack = 1'b1; bin = 128'h11; @(negedge clk);
    bin = 128'h22; @(negedge clk);
    ack = 1'b0; reset_n = 1'b0; #1;
    chk("mid_rst_line", lo, 0); chk("mid_rst_addr", ao, 0);
    chk("mid_rst_ctl", {ro, wo, rs}, 0); chk("mid_rst_burst", bo, 0);
    rd = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    do_read(32'h0000_3000, rand_beats(), 16'h0100, 1'b0);

    // randomized round trips on every configuration
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 4; n++) begin
        do_read($urandom, rand_beats(), 16'($urandom) & 16'h3333, 1'b0);
        do_write($urandom, rand_line(), 16'($urandom) & 16'h3333);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
